// File: rtl/bp_update_queue.sv
// bp_update_queue
// Collects resolved-branch predictor updates from three lanes and hands
// them to a single predictor write port, one per cycle, in lane/cycle order.
// Valid lanes are compacted in lane order before being written. Updates
// that do not fit are counted in drop_count, which saturates at 255, and
// also set the sticky overflow flag.
//
// Optional feature: define BP_UPD_BYPASS_EN so that, while the queue is
// empty, the lowest-ordered valid lane is forwarded straight to out_*.
// With the macro undefined, out_* are driven only from storage.
module bp_update_queue #(
    parameter int size  = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [size-1:0]          upd_pc_0,
    input  logic [size-1:0]          upd_pc_1,
    input  logic [size-1:0]          upd_pc_2,
    input  logic                     upd_valid_0,
    input  logic                     upd_valid_1,
    input  logic                     upd_valid_2,
    input  logic                     upd_mispred_0,
    input  logic                     upd_mispred_1,
    input  logic                     upd_mispred_2,
    output logic                     in_ready,
    output logic [size-1:0]          out_pc,
    output logic                     out_valid,
    output logic                     out_mispred,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [7:0]               drop_count,
    output logic                     overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Each entry is {pc, mispred}.
    logic [size:0]   mem_q [DEPTH];

    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      drop_q, drop_d;
    logic            ovf_q, ovf_d;

    logic [2:0]      lane_v;
    logic [size:0]   lane_e [3];
    logic [size:0]   comp [3];
    logic [size:0]   enq [3];
    logic [1:0]      n_valid;
    logic [1:0]      n_enq;
    logic [1:0]      n_wr;
    logic [1:0]      n_drop;
    logic [CW-1:0]   avail;
    logic [CW-1:0]   free_slots;
    logic            store_valid;
    logic            store_deq;
    logic            byp_act;
    logic            byp_take;
    logic [size:0]   head_e;

    // Gather the per-lane inputs into indexable form.
    always_comb begin
        lane_v    = {upd_valid_2, upd_valid_1, upd_valid_0};
        lane_e[0] = {upd_pc_0, upd_mispred_0};
        lane_e[1] = {upd_pc_1, upd_mispred_1};
        lane_e[2] = {upd_pc_2, upd_mispred_2};
    end

    // Compact the valid lanes in lane order: comp[0] is the lowest valid lane.
    always_comb begin
        n_valid = 2'd0;
        for (int k = 0; k < 3; k++) begin
            comp[k] = '0;
        end
        for (int l = 0; l < 3; l++) begin
            if (lane_v[l]) begin
                comp[n_valid] = lane_e[l];
                n_valid       = n_valid + 2'd1;
            end
        end
    end

    // Head-of-queue state and the optional empty-queue bypass path.
    always_comb begin
        store_valid = (count_q != '0);
        store_deq   = store_valid & out_ready;
`ifdef BP_UPD_BYPASS_EN
        byp_act     = (count_q == '0) && (lane_v != 3'b000);
`else
        byp_act     = 1'b0;
`endif
        byp_take    = byp_act & out_ready;
    end

    // Decide how many compacted updates are written and how many are dropped.
    always_comb begin
        // A bypassed update is consumed directly, so the write list skips it.
        enq[0] = byp_take ? comp[1] : comp[0];
        enq[1] = byp_take ? comp[2] : comp[1];
        enq[2] = byp_take ? '0      : comp[2];
        n_enq  = n_valid - {1'b0, byp_take};

        avail = DEPTH_C - count_q + CW'(store_deq);
        if (CW'(n_enq) < avail) begin
            n_wr = n_enq;
        end else begin
            n_wr = avail[1:0];
        end
        n_drop = n_enq - n_wr;
    end

    // Next-state values for pointers, count and the drop statistics.
    always_comb begin
        logic [8:0] drop_sum;
        head_d   = head_q + PW'(store_deq);
        tail_d   = tail_q + PW'(n_wr);
        count_d  = count_q + CW'(n_wr) - CW'(store_deq);
        drop_sum = {1'b0, drop_q} + 9'(n_drop);
        drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
        ovf_d    = ovf_q | (n_drop != 2'd0);
    end

    // Control registers; storage itself is deliberately left unreset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            drop_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            drop_q  <= drop_d;
            ovf_q   <= ovf_d;
        end
    end

    // Write up to three compacted updates contiguously from tail, wrapping.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (2'(k) < n_wr) begin
                mem_q[tail_q + PW'(k)] <= enq[k];
            end
        end
    end

    // Output drive; out_pc/out_mispred read as zero whenever nothing is valid.
    always_comb begin
        if (store_valid) begin
            head_e = mem_q[head_q];
        end else if (byp_act) begin
            head_e = comp[0];
        end else begin
            head_e = '0;
        end
        out_valid   = store_valid | byp_act;
        out_pc      = head_e[size:1];
        out_mispred = head_e[0];
        free_slots  = DEPTH_C - count_q;
        in_ready    = (free_slots >= CW'(3));
        occupancy   = count_q;
        drop_count  = drop_q;
        overflow    = ovf_q;
    end

endmodule

// File: tb/tb_bp_update_queue.sv
// Testbench for bp_update_queue: directed scenarios plus random traffic,
// checked against a queue-based reference model and a decoupled output monitor.
module tb_bp_update_queue;

    localparam int W     = 32;
    localparam int DEPTH = 8;

    logic            clk;
    logic            reset;
    logic [W-1:0]    upd_pc_0, upd_pc_1, upd_pc_2;
    logic            upd_valid_0, upd_valid_1, upd_valid_2;
    logic            upd_mispred_0, upd_mispred_1, upd_mispred_2;
    logic            in_ready;
    logic [W-1:0]    out_pc;
    logic            out_valid;
    logic            out_mispred;
    logic            out_ready;
    logic [$clog2(DEPTH):0] occupancy;
    logic [7:0]      drop_count;
    logic            overflow;

    bp_update_queue #(.size(W), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .upd_pc_0      (upd_pc_0),
        .upd_pc_1      (upd_pc_1),
        .upd_pc_2      (upd_pc_2),
        .upd_valid_0   (upd_valid_0),
        .upd_valid_1   (upd_valid_1),
        .upd_valid_2   (upd_valid_2),
        .upd_mispred_0 (upd_mispred_0),
        .upd_mispred_1 (upd_mispred_1),
        .upd_mispred_2 (upd_mispred_2),
        .in_ready      (in_ready),
        .out_pc        (out_pc),
        .out_valid     (out_valid),
        .out_mispred   (out_mispred),
        .out_ready     (out_ready),
        .occupancy     (occupancy),
        .drop_count    (drop_count),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: expected contents in order, plus statistics.
    logic [W:0] sb [$];
    int         m_size = 0;
    int         m_drop = 0;
    bit         m_ovf  = 0;
    bit         exp_out_valid = 0;
    bit         mon_active = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: whenever the DUT presents a head, compare it with the model's front.
    always @(negedge clk) begin
        if (reset && mon_active) begin
            chk("out_valid", longint'(out_valid), longint'(exp_out_valid));
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("head_present", 0, 1);
                end else begin
                    chk("out_pc", longint'(out_pc), longint'(sb[0][W:1]));
                    chk("out_mispred", longint'(out_mispred), longint'(sb[0][0]));
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    // One cycle: check registered state, drive lanes, advance the model.
    task automatic step(input bit [2:0] v, input logic [W-1:0] p0, input logic [W-1:0] p1,
                        input logic [W-1:0] p2, input bit [2:0] m, input bit rdy);
        logic [W:0] lst [$];
        int deq, avail, wr, drop;
        chk("occupancy", longint'(occupancy), longint'(m_size));
        chk("drop_count", longint'(drop_count), longint'(m_drop));
        chk("overflow", longint'(overflow), longint'(m_ovf));
        chk("in_ready", longint'(in_ready), longint'((DEPTH - m_size) >= 3));

        upd_valid_0 = v[0]; upd_valid_1 = v[1]; upd_valid_2 = v[2];
        upd_pc_0 = p0; upd_pc_1 = p1; upd_pc_2 = p2;
        upd_mispred_0 = m[0]; upd_mispred_1 = m[1]; upd_mispred_2 = m[2];
        out_ready = rdy;

        if (v[0]) lst.push_back({p0, m[0]});
        if (v[1]) lst.push_back({p1, m[1]});
        if (v[2]) lst.push_back({p2, m[2]});
        deq = (m_size > 0 && rdy) ? 1 : 0;
        exp_out_valid = (m_size > 0);
`ifdef BP_UPD_BYPASS_EN
        if (m_size == 0 && lst.size() > 0) begin
            exp_out_valid = 1;
            if (rdy) sb.push_back(lst.pop_front());
        end
`endif
        avail = DEPTH - m_size + deq;
        wr    = (lst.size() < avail) ? lst.size() : avail;
        for (int i = 0; i < wr; i++) sb.push_back(lst[i]);
        drop   = lst.size() - wr;
        m_drop = (m_drop + drop > 255) ? 255 : m_drop + drop;
        if (drop > 0) m_ovf = 1;
        m_size = m_size + wr - deq;

        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit rdy);
        step(3'b000, '0, '0, '0, 3'b000, rdy);
    endtask

    task automatic rand_step(input int rdy_pct);
        step(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
             3'($urandom_range(0, 7)), ($urandom_range(0, 99) < rdy_pct));
    endtask

    initial begin
        reset = 1'b0;
        {upd_valid_0, upd_valid_1, upd_valid_2} = 3'b000;
        {upd_mispred_0, upd_mispred_1, upd_mispred_2} = 3'b000;
        upd_pc_0 = '0; upd_pc_1 = '0; upd_pc_2 = '0;
        out_ready = 1'b0;
        #12;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_occupancy", longint'(occupancy), 0);
        chk("rst_in_ready", longint'(in_ready), 1);
        chk("rst_drop_count", longint'(drop_count), 0);
        chk("rst_overflow", longint'(overflow), 0);
        chk("rst_out_pc", longint'(out_pc), 0);
        chk("rst_out_mispred", longint'(out_mispred), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        mon_active = 1;
        @(posedge clk); #1;

        // Ordering across three lanes, consumer always ready.
        step(3'b111, 32'h100, 32'h104, 32'h108, 3'b010, 1'b1);
        repeat (4) idle(1'b1);

        // Compaction of lanes 0 and 2, then a single ready pulse.
        step(3'b101, 32'h200, 32'h0, 32'h208, 3'b000, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);
        repeat (2) idle(1'b1);

        // Overflow: nine updates into eight slots with no consumer.
        step(3'b111, 32'h500, 32'h504, 32'h508, 3'b001, 1'b0);
        step(3'b111, 32'h510, 32'h514, 32'h518, 3'b010, 1'b0);
        step(3'b111, 32'h520, 32'h524, 32'h528, 3'b100, 1'b0);
        idle(1'b0);
        // Full queue with a dequeue: freed slot reused by lane 0.
        step(3'b001, 32'h400, 32'h0, 32'h0, 3'b001, 1'b1);
        idle(1'b0);
        repeat (10) idle(1'b1);

        // Random traffic: light load, then heavy load with drops and wraps.
        repeat (200) rand_step(80);
        repeat (200) rand_step(25);
        repeat (12) idle(1'b1);

        // Saturate drop_count.
        repeat (100) step(3'b111, $urandom, $urandom, $urandom, 3'b000, 1'b0);
        idle(1'b0);
        step(3'b111, 32'h600, 32'h604, 32'h608, 3'b000, 1'b1);
        idle(1'b0);

        // Reset mid-operation: outputs drop immediately, statistics clear.
        reset = 1'b0;
        #1;
        chk("midrst_out_valid", longint'(out_valid), 0);
        chk("midrst_occupancy", longint'(occupancy), 0);
        chk("midrst_overflow", longint'(overflow), 0);
        sb.delete();
        m_size = 0; m_drop = 0; m_ovf = 0; exp_out_valid = 0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        repeat (100) rand_step(60);
        repeat (12) idle(1'b1);
        chk("scoreboard_drained", longint'(sb.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bp_update_queue.md
# bp_update_queue

Buffers resolved-branch predictor updates from the three execute/commit lanes and drains them one per cycle into a single predictor update port. It sits between the branch-resolution logic and the branch predictor, so the predictor can use one write port instead of three. Update order is preserved: lane 0 before lane 1 before lane 2 within a cycle, and earlier cycles before later ones. Overflow is detected, counted and flagged, never silent.

## Interface
- size, 32, PC width.
- DEPTH, 8, FIFO entries; power of two, ≥ 4.
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- upd_pc_0 / upd_pc_1 / upd_pc_2  input  size  PC of the resolved branch per lane.
- upd_valid_0 / upd_valid_1 / upd_valid_2  input  1  lane carries an update this cycle.
- upd_mispred_0 / upd_mispred_1 / upd_mispred_2  input  1  resolution disagreed with the prediction.
- in_ready  output  1  at least 3 free slots; a full 3-lane burst is guaranteed to be accepted.
- out_pc  output  size  PC of the head entry.
- out_valid  output  1  head entry is valid.
- out_mispred  output  1  misprediction flag of the head entry.
- out_ready  input  1  predictor consumes the head this cycle.
- occupancy  output  $clog2(DEPTH)+1  current entry count.
- drop_count  output  8  number of dropped updates; saturates at 255.
- overflow  output  1  sticky; set on the first drop.

## Operation
- **Storage:** circular buffer of {pc, mispred}, with head pointer, tail pointer and count registers. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- **Dequeue:**
  - deq = out_valid & out_ready.
  - out_* are driven from the head entry; out_valid = (count ≠ 0).
  - On deq, head advances by 1.
- **Enqueue:**
  - Valid lanes are compacted in lane order. Example: lanes 0 and 2 valid → two consecutive entries, lane 0 first.
  - Slots available this cycle: avail = DEPTH − count + deq.
  - The first min(n_valid, avail) compacted updates are written at tail, tail+1, tail+2 (mod DEPTH). Tail advances by the number written.
- **Drop:**
  - Any compacted update beyond avail is discarded. Because of compaction, only the highest-ordered valid lanes are ever dropped.
  - drop_count increases by the number discarded, saturating at 255.
  - overflow is set to 1 and holds until reset.
- **Count update:** count_next = count + written − deq.
- **in_ready:** combinational, = (DEPTH − count ≥ 3). It ignores the same-cycle dequeue, so it is conservative. Upstream must hold updates while it is low; the queue still accepts whatever fits.
- **State machine:** none beyond the FIFO. States are EMPTY (count=0), PARTIAL and FULL (count=DEPTH), all implied by count.

## Timing
- **Reset values** (asynchronous assertion, sampled deassertion):
  - head, tail, count, drop_count, occupancy = 0.
  - overflow = 0; out_valid = 0; in_ready = 1.
  - out_pc = 0, out_mispred = 0.
  - Storage contents are not reset.
- **Latency:** an update enqueued in cycle N is visible on out_* at cycle N+1 at the earliest (without bypass).
- **Throughput:** in 1 out / cycle; in 3 / cycle.
- **Full FIFO with deq:** 1 slot is freed and reused by lane-ordered input in the same cycle.
- **Hold behaviour:** out_valid with out_ready=0 keeps the head and out_* stable.
- **Wrap-around:** a burst of 3 that crosses index DEPTH−1 → 0 is written contiguously modulo DEPTH.
- **Reset mid-operation:** all entries are lost immediately; out_valid falls in the same cycle reset is asserted.

## Configuration
- **BP_UPD_BYPASS_EN defined:** when count=0 and at least one lane is valid, the lowest-ordered valid lane is driven combinationally onto out_* with out_valid=1.
  - If out_ready=1, that update is consumed without being written. The remaining lanes are enqueued normally (latency 0 for the bypassed update).
  - If out_ready=0, all valid lanes are enqueued as usual.
- **Undefined:** out_* come only from storage, with a minimum latency of 1 cycle.

## Test plan
- **Reset:** deassert reset, idle → out_valid=0, occupancy=0, in_ready=1, drop_count=0, overflow=0.
- **Ordering:** cycle 0 lanes 0/1/2 = PCs 0x100/0x104/0x108 (mispred 0/1/0), out_ready=1 → out_pc 0x100, 0x104, 0x108 in cycles 1–3; out_mispred 0, 1, 0.
- **Compaction:** only lanes 0 and 2 valid (0x200, 0x208), out_ready=0 → occupancy=2; head 0x200, then 0x208 after a single out_ready pulse.
- **Overflow:** DEPTH=8, out_ready=0, three full bursts (9 updates) → occupancy=8, drop_count=1, overflow=1, the lane-2 update of the third burst is lost, in_ready=0.
- **Full with dequeue:** count=8, out_ready=1, lane 0 valid → occupancy stays 8, drop_count unchanged; the new entry appears last after wrap-around.
- **Bypass:** with BP_UPD_BYPASS_EN, empty queue, lane 0 = 0x300, out_ready=1 → out_valid=1, out_pc=0x300 in the same cycle, occupancy stays 0; without the macro → out_pc=0x300 in the next cycle.
